rename_regfile_mp: RTL and testbench
====================================

// Module: rename_regfile_mp
// PURPOSE
// - Multi-port architectural register file with per-register ROB rename tags, for the superscalar core.
// - Generalises the single-issue register file:
//   - parametrised data width, register count, ROB depth and issue/commit width;
//   - in-group dependency forwarding between same-cycle issue slots;
//   - commit-to-read bypass;
//   - whole-file flush.
// - Sits between decode/issue (source lookup, rd tagging) and the ROB commit stage (writeback).
// PARAMETERS
// - XLEN      32  register data width
// - NREGS     32  architectural registers; index 0 hardwired to zero, never tagged
// - ROB_DEPTH 8   ROB entries; ROB_W = $clog2(ROB_DEPTH) = tag width
// - NISSUE    2   issue slots per cycle; each slot owns 2 read ports (rs1/rs2)
// - NCOMMIT   2   commit write ports per cycle; index 0 = oldest
// PORTS
// - clk_in            in   1                   clock, rising edge
// - rst_in            in   1                   synchronous, active-high reset
// - rs1_in[NISSUE]    in   $clog2(NREGS) each  slot source 1 address
// - rs2_in[NISSUE]    in   $clog2(NREGS) each  slot source 2 address
// - issue_in[NISSUE]  in   1 each              slot k issues an rd-writing instr this cycle
// - rd_in[NISSUE]     in   $clog2(NREGS) each  slot k destination
// - rob_ix_in[NISSUE] in   ROB_W each          slot k ROB index
// - we_in[NCOMMIT]    in   1 each              commit port c writes this cycle
// - wa_in[NCOMMIT]    in   $clog2(NREGS) each  commit destination
// - wd_in[NCOMMIT]    in   XLEN each           commit data
// - wrob_ix_in[NCOMMIT] in ROB_W each          ROB index of the committing instr
// - flush_in          in   1                   mispredict flush: drop all rename tags
// - rval1_out/rval2_out[NISSUE]  out XLEN each   source values
// - rob_ix1_out/rob_ix2_out[NISSUE] out ROB_W each source tags
// - rob1_valid_out/rob2_valid_out[NISSUE] out 1 each  1 = value pending in ROB, use tag
// - busy_count_out    out  $clog2(NREGS)+1     number of registers currently tagged (registered)
// BEHAVIOUR
// - Reset (dominates all inputs, any cycle): all NREGS regs = 0, tags = 0, valid = 0, busy_count_out = 0.
// - Reg 0 reads value 0 and valid 0 always; writes and issues to rd = 0 are ignored.
// - Reads are combinational, zero latency. Per source, priority highest first:
//   1. In-group forwarding: youngest slot j<k with issue_in[j] and rd_in[j] == rs, rd != 0
//      -> tag = rob_ix_in[j], valid = 1.
//   2. Commit bypass: else if commit c this cycle writes rs and clears its tag
//      -> value = wd_in[c] (highest c wins), valid = 0.
//   3. Stored state: value, tag and valid from the file.
// - Commit, next edge:
//   - registers[wa] <= wd; highest-index port wins on duplicate wa;
//   - valid/tag cleared only if valid[wa] and tag[wa] == wrob_ix.
// - Issue, next edge: tag[rd] <= rob_ix, valid[rd] <= 1.
//   - Duplicate rd across slots: highest slot wins.
//   - Issue to a reg beats a same-cycle commit clear of that reg.
// - Flush, next edge:
//   - all valid <= 0, tags <= 0;
//   - commit data writes still apply;
//   - issue_in ignored; busy_count_out <= 0.
// - busy_count_out = popcount of next-state valid bits, registered: updates 1 cycle after the causing event.
// - Tag compare is exact ROB_W-bit equality; ROB index wrap is handled by the ROB, not here.
// TESTING
// - Reset, then read all regs -> val 0, valid 0, busy 0; x31 included.
// - Issue slot0 rd=5 rob=3; next cycle slot0 rs1=5 -> valid 1, tag 3.
//   Commit wa=5 wrob=3 wd=0xDEAD -> same-cycle read val 0xDEAD, valid 0; busy 1 -> 0.
// - Stale commit: issue rd=7 rob=1, then rd=7 rob=4; commit wa=7 wrob=1 wd=0x11
//   -> reg7 = 0x11, valid 1, tag 4.
// - Same cycle: slot0 issue rd=9 rob=2, slot1 rs2=9
//   -> slot1 rob_ix2_out=2, valid 1; both slots rd=9 (rob 2, 5) -> stored tag 5.
// - Flush with commit wa=3 wd=0x42 and issue rd=4
//   -> reg3 = 0x42, all valid 0, reg4 untagged, busy 0 next cycle.
// - Reset asserted with we/issue/flush active -> all state 0; issue/commit to rd=0 -> no change.

Source files
------------

// File: rtl/rename_regfile_mp.sv
// Multi-port architectural register file with per-register ROB rename tags.
// Provides combinational source lookup with in-group forwarding and commit bypass.
module rename_regfile_mp #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned ROB_DEPTH = 8,
  parameter int unsigned NISSUE    = 2,
  parameter int unsigned NCOMMIT   = 2,
  localparam int unsigned RW       = $clog2(NREGS),
  localparam int unsigned ROB_W    = $clog2(ROB_DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [RW-1:0]    rs1_in         [NISSUE],
  input  logic [RW-1:0]    rs2_in         [NISSUE],
  input  logic             issue_in       [NISSUE],
  input  logic [RW-1:0]    rd_in          [NISSUE],
  input  logic [ROB_W-1:0] rob_ix_in      [NISSUE],
  input  logic             we_in          [NCOMMIT],
  input  logic [RW-1:0]    wa_in          [NCOMMIT],
  input  logic [XLEN-1:0]  wd_in          [NCOMMIT],
  input  logic [ROB_W-1:0] wrob_ix_in     [NCOMMIT],
  input  logic             flush_in,
  output logic [XLEN-1:0]  rval1_out      [NISSUE],
  output logic [XLEN-1:0]  rval2_out      [NISSUE],
  output logic [ROB_W-1:0] rob_ix1_out    [NISSUE],
  output logic [ROB_W-1:0] rob_ix2_out    [NISSUE],
  output logic             rob1_valid_out [NISSUE],
  output logic             rob2_valid_out [NISSUE],
  output logic [RW:0]      busy_count_out
);

  logic [XLEN-1:0]  r_val [NREGS];
  logic [ROB_W-1:0] r_tag [NREGS];
  logic [NREGS-1:0] r_valid;
  logic [RW:0]      r_busy;

  logic [ROB_W-1:0] w_tag_nxt [NREGS];
  logic [NREGS-1:0] w_valid_nxt;
  logic [RW:0]      w_busy_nxt;

  // Commit clears are judged against the pre-edge tags; issue then overrides.
  always_comb begin
    w_valid_nxt = r_valid;
    w_tag_nxt   = r_tag;
    w_busy_nxt  = '0;
    for (int unsigned c = 0; c < NCOMMIT; c++) begin
      if (we_in[c] && wa_in[c] != '0 && r_valid[wa_in[c]] &&
          r_tag[wa_in[c]] == wrob_ix_in[c]) begin
        w_valid_nxt[wa_in[c]] = 1'b0;
        w_tag_nxt[wa_in[c]]   = '0;
      end
    end
    if (flush_in) begin
      w_valid_nxt = '0;
      for (int unsigned i = 0; i < NREGS; i++) w_tag_nxt[i] = '0;
    end else begin
      for (int unsigned k = 0; k < NISSUE; k++) begin
        if (issue_in[k] && rd_in[k] != '0) begin
          w_valid_nxt[rd_in[k]] = 1'b1;
          w_tag_nxt[rd_in[k]]   = rob_ix_in[k];
        end
      end
    end
    for (int unsigned i = 0; i < NREGS; i++)
      w_busy_nxt = w_busy_nxt + (RW+1)'(w_valid_nxt[i]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= '0;
      r_busy  <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_tag   <= w_tag_nxt;
      r_busy  <= w_busy_nxt;
      for (int unsigned c = 0; c < NCOMMIT; c++)
        if (we_in[c] && wa_in[c] != '0) r_val[wa_in[c]] <= wd_in[c];
    end
  end

  assign busy_count_out = r_busy;

  // Source lookup: stored state, then commit bypass, then older-slot forwarding.
  always_comb begin
    logic [RW-1:0]    w_rs;
    logic [XLEN-1:0]  w_v;
    logic [ROB_W-1:0] w_t;
    logic             w_ok;
    for (int unsigned k = 0; k < NISSUE; k++) begin
      rval1_out[k]      = '0;
      rval2_out[k]      = '0;
      rob_ix1_out[k]    = '0;
      rob_ix2_out[k]    = '0;
      rob1_valid_out[k] = 1'b0;
      rob2_valid_out[k] = 1'b0;
      for (int unsigned s = 0; s < 2; s++) begin
        w_rs = (s == 0) ? rs1_in[k] : rs2_in[k];
        w_v  = r_val[w_rs];
        w_t  = r_tag[w_rs];
        w_ok = r_valid[w_rs];
        for (int unsigned c = 0; c < NCOMMIT; c++) begin
          if (we_in[c] && wa_in[c] == w_rs && r_valid[w_rs] &&
              r_tag[w_rs] == wrob_ix_in[c]) begin
            w_v  = wd_in[c];
            w_t  = '0;
            w_ok = 1'b0;
          end
        end
        for (int unsigned j = 0; j < k; j++) begin
          if (issue_in[j] && rd_in[j] == w_rs) begin
            w_t  = rob_ix_in[j];
            w_ok = 1'b1;
          end
        end
        if (w_rs == '0) begin
          w_v  = '0;
          w_t  = '0;
          w_ok = 1'b0;
        end
        if (s == 0) begin
          rval1_out[k]      = w_v;
          rob_ix1_out[k]    = w_t;
          rob1_valid_out[k] = w_ok;
        end else begin
          rval2_out[k]      = w_v;
          rob_ix2_out[k]    = w_t;
          rob2_valid_out[k] = w_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Directed bench for rename_regfile_mp: reference model checked every cycle
// plus hand-computed literal expectations at key points.
module tb_rename_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1 [2];
  logic [4:0]  rs2 [2];
  logic        issue [2];
  logic [4:0]  rd [2];
  logic [2:0]  rob [2];
  logic        we [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [2:0]  wrob [2];
  logic        flush;
  logic [31:0] rval1 [2];
  logic [31:0] rval2 [2];
  logic [2:0]  rix1 [2];
  logic [2:0]  rix2 [2];
  logic        rv1 [2];
  logic        rv2 [2];
  logic [5:0]  busy;

  int errors = 0;
  int checks = 0;

  rename_regfile_mp #(.XLEN(32), .NREGS(32), .ROB_DEPTH(8), .NISSUE(2), .NCOMMIT(2)) dut (
    .clk_in(clk), .rst_in(rst),
    .rs1_in(rs1), .rs2_in(rs2), .issue_in(issue), .rd_in(rd), .rob_ix_in(rob),
    .we_in(we), .wa_in(wa), .wd_in(wd), .wrob_ix_in(wrob), .flush_in(flush),
    .rval1_out(rval1), .rval2_out(rval2), .rob_ix1_out(rix1), .rob_ix2_out(rix2),
    .rob1_valid_out(rv1), .rob2_valid_out(rv2), .busy_count_out(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: architectural value, pending flag and owning ROB tag per register.
  logic [31:0] m_val [32];
  logic [2:0]  m_tag [32];
  bit          m_pend [32];
  bit          started = 0;

  function automatic int pend_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic void exp_read(input int k, input int r, output logic [31:0] v,
                                   output logic [2:0] t, output bit ok);
    v = m_val[r]; t = m_tag[r]; ok = m_pend[r];
    for (int c = 0; c < 2; c++)
      if (we[c] && int'(wa[c]) == r && m_pend[r] && m_tag[r] == wrob[c]) begin
        v = wd[c]; t = 3'd0; ok = 0;
      end
    for (int j = 0; j < k; j++)
      if (issue[j] && int'(rd[j]) == r) begin t = rob[j]; ok = 1; end
    if (r == 0) begin v = 32'd0; t = 3'd0; ok = 0; end
  endfunction

  task automatic chk_src(input string name, input int k, input int r, input logic [31:0] av,
                         input logic [2:0] at, input logic aok);
    logic [31:0] v; logic [2:0] t; bit ok;
    exp_read(k, r, v, t, ok);
    chk($sformatf("%s slot%0d x%0d valid", name, k, r), 32'(aok), 32'(ok));
    chk($sformatf("%s slot%0d x%0d tag", name, k, r), 32'(at), 32'(t));
    if (!ok) chk($sformatf("%s slot%0d x%0d value", name, k, r), av, v);
  endtask

  initial begin
    bit          old_pend [32];
    logic [2:0]  old_tag [32];
    forever begin
      @(negedge clk);
      if (started) begin
        chk("model busy", 32'(busy), 32'(pend_count()));
        if (!rst && !(flush && (issue[0] || issue[1]))) begin
          for (int k = 0; k < 2; k++) begin
            chk_src("model rs1", k, int'(rs1[k]), rval1[k], rix1[k], rv1[k]);
            chk_src("model rs2", k, int'(rs2[k]), rval2[k], rix2[k], rv2[k]);
          end
        end
      end
      if (rst) begin
        for (int i = 0; i < 32; i++) begin m_val[i] = '0; m_tag[i] = '0; m_pend[i] = 0; end
        started = 1;
      end else if (started) begin
        old_pend = m_pend; old_tag = m_tag;
        for (int c = 0; c < 2; c++)
          if (we[c] && wa[c] != 5'd0) begin
            m_val[wa[c]] = wd[c];
            if (old_pend[wa[c]] && old_tag[wa[c]] == wrob[c]) begin
              m_pend[wa[c]] = 0; m_tag[wa[c]] = 3'd0;
            end
          end
        if (flush) begin
          for (int i = 0; i < 32; i++) begin m_pend[i] = 0; m_tag[i] = 3'd0; end
        end else begin
          for (int k = 0; k < 2; k++)
            if (issue[k] && rd[k] != 5'd0) begin m_pend[rd[k]] = 1; m_tag[rd[k]] = rob[k]; end
        end
      end
    end
  end

  task automatic clr();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rs1[i] = '0; rs2[i] = '0; issue[i] = 1'b0; rd[i] = '0; rob[i] = '0;
      we[i] = 1'b0; wa[i] = '0; wd[i] = '0; wrob[i] = '0;
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Every register reads zero and untagged after reset.
    for (int i = 0; i < 16; i++) begin
      rs1[0] = 5'(2*i); rs2[0] = 5'(2*i+1); rs1[1] = 5'(31-2*i); rs2[1] = 5'(30-2*i);
      mid();
      if (i == 0) begin
        chk("x31 value", rval1[1], 32'd0);
        chk("x31 valid", 32'(rv1[1]), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
      end
      nxt();
    end

    issue[0] = 1; rd[0] = 5'd5; rob[0] = 3'd3;
    nxt();
    rs1[0] = 5'd5;
    mid();
    chk("x5 tagged valid", 32'(rv1[0]), 32'd1);
    chk("x5 tag", 32'(rix1[0]), 32'd3);
    chk("busy after issue", 32'(busy), 32'd1);
    nxt();
    rs1[0] = 5'd5; we[0] = 1; wa[0] = 5'd5; wrob[0] = 3'd3; wd[0] = 32'hDEAD;
    mid();
    chk("bypass value", rval1[0], 32'hDEAD);
    chk("bypass valid", 32'(rv1[0]), 32'd0);
    chk("busy during commit", 32'(busy), 32'd1);
    nxt();
    rs1[0] = 5'd5;
    mid();
    chk("busy after commit", 32'(busy), 32'd0);
    chk("x5 stored", rval1[0], 32'hDEAD);
    nxt();

    issue[0] = 1; rd[0] = 5'd7; rob[0] = 3'd1;
    nxt();
    issue[0] = 1; rd[0] = 5'd7; rob[0] = 3'd4;
    nxt();
    rs1[0] = 5'd7; we[0] = 1; wa[0] = 5'd7; wrob[0] = 3'd1; wd[0] = 32'h11;
    mid();
    chk("stale commit no bypass", 32'(rv1[0]), 32'd1);
    chk("stale commit tag", 32'(rix1[0]), 32'd4);
    nxt();
    rs1[0] = 5'd7;
    mid();
    chk("x7 still tagged", 32'(rix1[0]), 32'd4);
    chk("busy x7", 32'(busy), 32'd1);
    nxt();

    issue[0] = 1; rd[0] = 5'd9; rob[0] = 3'd2; rs2[1] = 5'd9;
    mid();
    chk("in-group fwd tag", 32'(rix2[1]), 32'd2);
    chk("in-group fwd valid", 32'(rv2[1]), 32'd1);
    nxt();
    issue[0] = 1; rd[0] = 5'd9; rob[0] = 3'd2; issue[1] = 1; rd[1] = 5'd9; rob[1] = 3'd5;
    nxt();
    rs1[0] = 5'd9;
    mid();
    chk("dup rd slot1 wins", 32'(rix1[0]), 32'd5);
    chk("busy x7 x9", 32'(busy), 32'd2);
    nxt();

    issue[0] = 1; rd[0] = 5'd20; rob[0] = 3'd7;
    nxt();
    rs1[1] = 5'd20;
    we[0] = 1; wa[0] = 5'd20; wrob[0] = 3'd7; wd[0] = 32'hA;
    we[1] = 1; wa[1] = 5'd20; wrob[1] = 3'd7; wd[1] = 32'hB;
    mid();
    chk("dual bypass port1 wins", rval1[1], 32'hB);
    chk("busy three", 32'(busy), 32'd3);
    nxt();
    rs1[1] = 5'd20;
    mid();
    chk("dual commit stored", rval1[1], 32'hB);
    chk("busy after dual", 32'(busy), 32'd2);
    nxt();

    flush = 1; we[0] = 1; wa[0] = 5'd3; wd[0] = 32'h42; wrob[0] = 3'd0;
    issue[0] = 1; rd[0] = 5'd4; rob[0] = 3'd6;
    nxt();
    rs1[0] = 5'd3; rs2[0] = 5'd4; rs1[1] = 5'd7;
    mid();
    chk("flush commit data", rval1[0], 32'h42);
    chk("flush issue ignored", 32'(rv2[0]), 32'd0);
    chk("x7 after flush", rval1[1], 32'h11);
    chk("x7 untagged", 32'(rv1[1]), 32'd0);
    chk("busy after flush", 32'(busy), 32'd0);
    nxt();

    issue[0] = 1; rd[0] = 5'd10; rob[0] = 3'd1; issue[1] = 1; rd[1] = 5'd11; rob[1] = 3'd2;
    we[0] = 1; wa[0] = 5'd12; wd[0] = 32'h99;
    nxt();
    rst = 1; flush = 1; we[0] = 1; wa[0] = 5'd13; wd[0] = 32'h5;
    issue[0] = 1; rd[0] = 5'd14; rob[0] = 3'd3;
    nxt();
    rst = 0;
    rs1[0] = 5'd12; rs2[0] = 5'd10; rs1[1] = 5'd11; rs2[1] = 5'd13;
    mid();
    chk("reset clears x12", rval1[0], 32'd0);
    chk("reset clears tag x10", 32'(rv2[0]), 32'd0);
    chk("reset clears tag x11", 32'(rv1[1]), 32'd0);
    chk("reset blocks commit", rval2[1], 32'd0);
    chk("busy after reset", 32'(busy), 32'd0);
    nxt();

    issue[0] = 1; rd[0] = 5'd0; rob[0] = 3'd3;
    we[0] = 1; wa[0] = 5'd0; wd[0] = 32'hFF; wrob[0] = 3'd3;
    rs1[1] = 5'd0;
    mid();
    chk("x0 no forward", 32'(rv1[1]), 32'd0);
    nxt();
    rs1[0] = 5'd0;
    mid();
    chk("x0 value", rval1[0], 32'd0);
    chk("x0 valid", 32'(rv1[0]), 32'd0);
    chk("busy x0 ignored", 32'(busy), 32'd0);
    nxt();
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
